// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: light encodings, debounce FSM states,
// default counter width and a helper that decides whether the secondary
// road is currently released.
package tl_pkg;

    localparam logic [1:0] LIGHT_DARK   = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b10,
        FALL_CHK = 2'b11
    } deb_state_t;

    // Cars may only leave the stop line while the light is yellow or green.
    function automatic logic light_released(input logic [1:0] light);
        return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Loop-detector conditioning: 2-flop synchroniser followed by a debounce
// FSM. evt_o is high for exactly one cycle, in the cycle before the FSM
// enters HIGH; it decodes registered state only, so the raw sensor has no
// combinational path to it. The caller registers it.
module sensor_debounce
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_i,
    output logic evt_o
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    deb_state_t state_q;
    logic [3:0] cnt_q;

    // Two-stage synchroniser for the asynchronous loop input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM: a level change is accepted after DEB_CYCLES further
    // consecutive samples at the new level (the sample that leaves a stable
    // state does not count).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                LOW: begin
                    cnt_q <= '0;
                    if (sync2_q) state_q <= RISE_CHK;
                end
                RISE_CHK: begin
                    if (!sync2_q) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HIGH: begin
                    cnt_q <= '0;
                    if (!sync2_q) state_q <= FALL_CHK;
                end
                FALL_CHK: begin
                    if (sync2_q) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign evt_o = (state_q == RISE_CHK) && sync2_q && (cnt_q == DEB_LAST);

endmodule

// File: rtl/sr_queue_counter.sv
// Secondary-road queue counter. Debounced arrival/departure events drive a
// saturating occupancy count with sticky overflow/underflow flags.
// Departures are only credited while the secondary light is yellow/green.
// Optional feature macro: SRQ_PEAK_EN adds peak_clr/peak_cars and a
// high-water-mark register.
module sr_queue_counter
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_CNT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr_sensor,
    input  logic             dep_sensor,
    input  logic [1:0]       SR_ctl,
    output logic [CNT_W-1:0] cars,
    output logic             arr_evt,
    output logic             dep_evt,
    output logic             ovf,
    output logic             udf
`ifdef SRQ_PEAK_EN
    ,
    input  logic             peak_clr,
    output logic [CNT_W-1:0] peak_cars
`endif
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

    logic             arr_fire;
    logic             dep_fire;
    logic             dep_ok;
    logic             arr_evt_q;
    logic             dep_evt_q;
    logic             ovf_q;
    logic             udf_q;
    logic [CNT_W-1:0] cars_q;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arr_deb (
        .clk      (clk),
        .rst      (rst),
        .sensor_i (arr_sensor),
        .evt_o    (arr_fire)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dep_deb (
        .clk      (clk),
        .rst      (rst),
        .sensor_i (dep_sensor),
        .evt_o    (dep_fire)
    );

    assign dep_ok = light_released(SR_ctl);

    // Register the event pulses; departures are gated by the light here.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_evt_q <= 1'b0;
            dep_evt_q <= 1'b0;
        end else begin
            arr_evt_q <= arr_fire;
            dep_evt_q <= dep_fire && dep_ok;
        end
    end

    // Saturating count and sticky flags; a simultaneous arrival and
    // departure cancel without touching either flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cars_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (dep_fire && !dep_ok) udf_q <= 1'b1;
            case ({arr_evt_q, dep_evt_q})
                2'b10: begin
                    if (cars_q < MAX_V) cars_q <= cars_q + CNT_W'(1);
                    else                ovf_q  <= 1'b1;
                end
                2'b01: begin
                    if (cars_q != '0) cars_q <= cars_q - CNT_W'(1);
                    else              udf_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SRQ_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    // High-water mark of the queue; a clear restarts it from the current count.
    always_ff @(posedge clk) begin
        if (rst)                  peak_q <= '0;
        else if (peak_clr)        peak_q <= cars_q;
        else if (cars_q > peak_q) peak_q <= cars_q;
    end

    assign peak_cars = peak_q;
`endif

    assign cars    = cars_q;
    assign arr_evt = arr_evt_q;
    assign dep_evt = dep_evt_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule
